// File: rtl/line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// line_buffer_pkg : bank-state type, window centre range and clamp helper
// Revision 1.0
// ============================================================================
package line_buffer_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FULL    = 2'd1,
      BANK_READING = 2'd2
   } bank_state_e;

   localparam logic MODE_VALID     = 1'b0;
   localparam logic MODE_REPLICATE = 1'b1;

   function automatic int center_first(logic mode, int r);
      return (mode == MODE_REPLICATE) ? 0 : r;
   endfunction

   function automatic int center_last(logic mode, int line_w, int r);
      return (mode == MODE_REPLICATE) ? line_w - 1 : line_w - 1 - r;
   endfunction

   function automatic int clamp(int v, int lo, int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_bank.sv
`default_nettype none
// ============================================================================
// line_bank : one line of pixel storage, one write port, TAPS clamped read taps
// Revision 1.0
// ============================================================================
module line_bank
   import line_buffer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LINE_W = 640,
   parameter int TAPS   = 3
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(LINE_W)-1:0]  wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [$clog2(LINE_W)-1:0]  rd_center,
   output logic [TAPS*DATA_W-1:0]     rd_win
);

   localparam int AW = $clog2(LINE_W);
   localparam int R  = (TAPS - 1) / 2;

   logic [DATA_W-1:0] mem [LINE_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Tap 0 lands in the most significant slice of the window.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      logic [AW-1:0] addr;
      assign addr = AW'(clamp(int'(rd_center) + k - R, 0, LINE_W - 1));
      assign rd_win[(TAPS-1-k)*DATA_W +: DATA_W] = mem[addr];
   end

endmodule
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// line_window_buffer : ping-pong line buffer emitting TAPS-wide sliding windows
// Revision 1.0
// ============================================================================
module line_window_buffer
   import line_buffer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LINE_W = 640,
   parameter int TAPS   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic                       edge_mode,
   output logic [TAPS*DATA_W-1:0]     win_data,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [$clog2(LINE_W)-1:0]  win_center,
   output logic                       line_done
);

   localparam int AW    = $clog2(LINE_W);
   localparam int R     = (TAPS - 1) / 2;
   localparam int WIN_W = TAPS * DATA_W;

   bank_state_e       bank_state [2];
   logic [1:0]        bank_mode;
   logic              line_mode;
   logic              wr_bank;
   logic              rd_bank;
   logic [AW-1:0]     wr_col;
   logic [WIN_W-1:0]  bank_win [2];

   logic              wr_fire;
   logic              wr_last;
   logic              win_fire;
   logic              win_last;
   logic              load;
   logic              load_bank;
   logic              load_new_line;
   logic [AW-1:0]     load_center;

   assign wr_ready = (bank_state[wr_bank] == BANK_EMPTY);
   assign wr_fire  = wr_valid && wr_ready;
   assign wr_last  = wr_fire && (wr_col == AW'(LINE_W - 1));

   // Pick the next window: continue the current line, or start the first
   // window of whichever bank the read side is moving to.
   always_comb begin
      win_fire      = win_valid && win_ready;
      win_last      = win_fire &&
                      (win_center == AW'(center_last(bank_mode[rd_bank], LINE_W, R)));
      load          = 1'b0;
      load_new_line = 1'b0;
      load_bank     = rd_bank;
      load_center   = win_center + AW'(1);
      if (win_last) begin
         load_bank     = ~rd_bank;
         load          = (bank_state[~rd_bank] == BANK_FULL);
         load_new_line = 1'b1;
         load_center   = AW'(center_first(bank_mode[~rd_bank], R));
      end else if (win_fire) begin
         load = 1'b1;
      end else if (!win_valid) begin
         load          = (bank_state[rd_bank] == BANK_FULL);
         load_new_line = 1'b1;
         load_center   = AW'(center_first(bank_mode[rd_bank], R));
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      line_bank #(
         .DATA_W (DATA_W),
         .LINE_W (LINE_W),
         .TAPS   (TAPS)
      ) u_bank (
         .clk       (clk),
         .wr_en     (wr_fire && (wr_bank == 1'(b))),
         .wr_addr   (wr_col),
         .wr_data   (wr_data),
         .rd_center (load_center),
         .rd_win    (bank_win[b])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_state[0] <= BANK_EMPTY;
         bank_state[1] <= BANK_EMPTY;
         bank_mode     <= {MODE_VALID, MODE_VALID};
         line_mode     <= MODE_VALID;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         wr_col        <= '0;
         win_data      <= '0;
         win_valid     <= 1'b0;
         win_center    <= '0;
         line_done     <= 1'b0;
      end else begin
         line_done <= win_last;

         // Mode is sampled on the first pixel so later toggles cannot leak in.
         if (wr_fire) begin
            if (wr_col == '0) begin
               line_mode <= edge_mode;
            end
            if (wr_last) begin
               wr_col                 <= '0;
               bank_state[wr_bank]    <= BANK_FULL;
               bank_mode[wr_bank]     <= line_mode;
               wr_bank                <= ~wr_bank;
            end else begin
               wr_col <= wr_col + AW'(1);
            end
         end

         if (win_last) begin
            bank_state[rd_bank] <= BANK_EMPTY;
            rd_bank             <= ~rd_bank;
         end

         if (load) begin
            win_data   <= bank_win[load_bank];
            win_center <= load_center;
            win_valid  <= 1'b1;
            if (load_new_line) begin
               bank_state[load_bank] <= BANK_READING;
            end
         end else if (win_fire) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
// tb_line_window_buffer : scoreboard bench for a small and a wide configuration
// Revision 1.0
// ============================================================================
module tb_line_window_buffer;

   localparam int S_DW = 8,  S_LW = 8,   S_T = 3;
   localparam int L_DW = 10, L_LW = 640, L_T = 5;
   localparam int MAXW = 64;

   typedef struct {
      logic [MAXW-1:0] data;
      int              center;
      bit              last;
   } win_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst;
   logic [S_DW-1:0]           s_wr_data;
   logic                      s_wr_valid, s_wr_ready, s_edge_mode;
   logic [S_T*S_DW-1:0]       s_win_data;
   logic                      s_win_valid, s_win_ready, s_line_done;
   logic [$clog2(S_LW)-1:0]   s_win_center;

   logic                      l_rst;
   logic [L_DW-1:0]           l_wr_data;
   logic                      l_wr_valid, l_wr_ready, l_edge_mode;
   logic [L_T*L_DW-1:0]       l_win_data;
   logic                      l_win_valid, l_win_ready, l_line_done;
   logic [$clog2(L_LW)-1:0]   l_win_center;

   line_window_buffer #(.DATA_W(S_DW), .LINE_W(S_LW), .TAPS(S_T)) u_small (
      .clk(clk), .rst(rst), .wr_data(s_wr_data), .wr_valid(s_wr_valid),
      .wr_ready(s_wr_ready), .edge_mode(s_edge_mode), .win_data(s_win_data),
      .win_valid(s_win_valid), .win_ready(s_win_ready),
      .win_center(s_win_center), .line_done(s_line_done));

   line_window_buffer #(.DATA_W(L_DW), .LINE_W(L_LW), .TAPS(L_T)) u_wide (
      .clk(clk), .rst(l_rst), .wr_data(l_wr_data), .wr_valid(l_wr_valid),
      .wr_ready(l_wr_ready), .edge_mode(l_edge_mode), .win_data(l_win_data),
      .win_valid(l_win_valid), .win_ready(l_win_ready),
      .win_center(l_win_center), .line_done(l_line_done));

   int   n_cmp = 0;
   int   n_bad = 0;
   win_t s_q[$];
   win_t l_q[$];
   bit   s_rand_ready = 1'b0;
   int   s_block = 0;
   bit   l_done = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(string msg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", msg);
   endtask

   // Reference: every window of a line, straight from the clamp-index rule.
   function automatic void push_expected(bit wide, int pix[$], int lw, int taps,
                                         int dw, bit mode);
      int r, first, last, idx;
      win_t w;
      r     = (taps - 1) / 2;
      first = mode ? 0 : r;
      last  = mode ? lw - 1 : lw - 1 - r;
      for (int c = first; c <= last; c++) begin
         w.data   = '0;
         w.center = c;
         w.last   = (c == last);
         for (int k = 0; k < taps; k++) begin
            idx = c - r + k;
            if (idx < 0) idx = 0;
            if (idx > lw - 1) idx = lw - 1;
            w.data = (w.data << dw) | MAXW'(pix[idx]);
         end
         if (wide) l_q.push_back(w);
         else      s_q.push_back(w);
      end
   endfunction

   initial begin
      s_win_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (s_block > 0) begin
            s_win_ready = 1'b0;
            s_block--;
         end else if (s_rand_ready) begin
            s_win_ready = ($urandom_range(0, 99) < 60);
         end else begin
            s_win_ready = 1'b1;
         end
      end
   end

   initial begin : s_mon
      logic [S_T*S_DW-1:0]     hold_d;
      logic [$clog2(S_LW)-1:0] hold_c;
      bit   holding;
      bit   exp_done;
      win_t e;
      holding  = 1'b0;
      exp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            holding  = 1'b0;
            exp_done = 1'b0;
            continue;
         end
         check("s_line_done", s_line_done, exp_done);
         if (s_line_done) check("s_wr_ready_at_done", s_wr_ready, 1'b1);
         exp_done = 1'b0;
         if (holding && s_win_valid) begin
            check("s_stall_data", s_win_data, hold_d);
            check("s_stall_center", s_win_center, hold_c);
         end
         holding = 1'b0;
         if (s_win_valid && s_win_ready) begin
            if (s_q.size() == 0) begin
               fail_now($sformatf("s_extra_window centre %0d, no window expected",
                                  s_win_center));
            end else begin
               e = s_q.pop_front();
               check("s_win_data", s_win_data, e.data);
               check("s_win_center", s_win_center, e.center);
               exp_done = e.last;
            end
         end else if (s_win_valid) begin
            holding = 1'b1;
            hold_d  = s_win_data;
            hold_c  = s_win_center;
         end
      end
   end

   initial begin : l_mon
      bit   exp_done;
      int   cnt;
      win_t e;
      exp_done = 1'b0;
      cnt      = 0;
      forever begin
         @(negedge clk);
         if (!l_rst) continue;
         check("l_line_done", l_line_done, exp_done);
         exp_done = 1'b0;
         if (l_win_valid && l_win_ready) begin
            if (l_q.size() == 0) begin
               fail_now($sformatf("l_extra_window centre %0d, no window expected",
                                  l_win_center));
            end else begin
               e = l_q.pop_front();
               cnt++;
               check("l_win_data", l_win_data, e.data);
               check("l_win_center", l_win_center, e.center);
               exp_done = e.last;
               if (e.last) begin
                  check("l_window_count", cnt, (e.center == L_LW - 1) ? L_LW : L_LW - L_T + 1);
                  cnt = 0;
               end
            end
         end
      end
   end

   task automatic s_write_line(int pix[$], bit mode, bit gaps, int npix);
      int t;
      if (npix == S_LW) push_expected(1'b0, pix, S_LW, S_T, S_DW, mode);
      for (int i = 0; i < npix; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_wr_valid = 1'b0;
            @(posedge clk); #1;
         end
         s_wr_valid  = 1'b1;
         s_wr_data   = S_DW'(pix[i]);
         s_edge_mode = mode;
         t = 0;
         @(negedge clk);
         while (!s_wr_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (!s_wr_ready) fail_now("s_write_timeout wr_ready 0, required 1 within 200 cycles");
         @(posedge clk); #1;
      end
      s_wr_valid = 1'b0;
   endtask

   task automatic s_drain();
      int t;
      t = 0;
      while ((s_q.size() != 0 || s_win_valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) fail_now($sformatf("s_drain %0d windows outstanding, 0 required", s_q.size()));
      @(posedge clk); #1;
   endtask

   task automatic s_check_reset();
      check("s_rst_wr_ready", s_wr_ready, 1'b1);
      check("s_rst_win_valid", s_win_valid, 1'b0);
      check("s_rst_win_data", s_win_data, '0);
      check("s_rst_win_center", s_win_center, '0);
      check("s_rst_line_done", s_line_done, 1'b0);
   endtask

   function automatic void rand_line(output int pix[$]);
      pix = {};
      for (int i = 0; i < S_LW; i++) pix.push_back(int'($urandom_range(0, 255)));
   endfunction

   // Wide configuration: two lines streamed back to back, continuous ready.
   initial begin : l_stim
      int pix[$];
      int t;
      l_rst = 1'b1; l_wr_valid = 1'b0; l_wr_data = '0; l_edge_mode = 1'b0;
      l_win_ready = 1'b1;
      #1 l_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("l_rst_wr_ready", l_wr_ready, 1'b1);
      check("l_rst_win_valid", l_win_valid, 1'b0);
      l_rst = 1'b1;
      for (int line = 0; line < 2; line++) begin
         pix = {};
         for (int i = 0; i < L_LW; i++) pix.push_back(int'($urandom_range(0, 1023)));
         push_expected(1'b1, pix, L_LW, L_T, L_DW, line[0]);
         for (int i = 0; i < L_LW; i++) begin
            l_wr_valid  = 1'b1;
            l_wr_data   = L_DW'(pix[i]);
            l_edge_mode = line[0];
            t = 0;
            @(negedge clk);
            while (!l_wr_ready && t < 2000) begin
               @(negedge clk);
               t++;
            end
            if (!l_wr_ready) fail_now("l_write_timeout wr_ready 0, required 1");
            @(posedge clk); #1;
         end
         l_wr_valid = 1'b0;
      end
      t = 0;
      while ((l_q.size() != 0 || l_win_valid) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) fail_now($sformatf("l_drain %0d windows outstanding, 0 required", l_q.size()));
      l_done = 1'b1;
   end

   initial begin : s_stim
      int pix[$];
      rst = 1'b1; s_wr_valid = 1'b0; s_wr_data = '0; s_edge_mode = 1'b0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      s_check_reset();
      rst = 1'b1;
      @(posedge clk); #1;

      pix = {1, 2, 3, 4, 5, 6, 7, 8};
      s_write_line(pix, 1'b0, 1'b0, S_LW);
      s_drain();
      s_write_line(pix, 1'b1, 1'b0, S_LW);
      s_drain();

      // Explicit three-cycle stall in the middle of a line.
      rand_line(pix);
      s_write_line(pix, 1'b1, 1'b0, S_LW);
      repeat (2) @(posedge clk);
      #1 s_block = 3;
      s_drain();

      s_rand_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         rand_line(pix);
         s_write_line(pix, 1'($urandom_range(0, 1)), 1'b1, S_LW);
      end
      s_drain();
      s_rand_ready = 1'b0;
      s_drain();

      // Ping-pong: second line fills while the first is still being read.
      rand_line(pix);
      s_write_line(pix, 1'b1, 1'b0, S_LW);
      rand_line(pix);
      s_write_line(pix, 1'b1, 1'b0, S_LW);
      check("s_wr_ready_both_full", s_wr_ready, 1'b0);
      rand_line(pix);
      s_write_line(pix, 1'b0, 1'b0, S_LW);
      s_drain();

      // Reset five pixels into a second line, then a clean fresh line.
      rand_line(pix);
      s_write_line(pix, 1'b0, 1'b0, S_LW);
      rand_line(pix);
      s_write_line(pix, 1'b0, 1'b0, 5);
      rst = 1'b0;
      s_q.delete();
      #1;
      s_check_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      rand_line(pix);
      s_write_line(pix, 1'b1, 1'b0, S_LW);
      s_drain();

      for (int i = 0; i < 20000 && !l_done; i++) @(posedge clk);
      if (!l_done) fail_now("l_timeout wide run did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
